// File: rtl/game_pkg.sv
// EatUp game sequencer: shared state encoding and defaults.
// Imported by the control block and its bus interface.
package game_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int LIVES_W          = 3;
  localparam int DEF_MOVE_DIV     = 4;
  localparam int DEF_LIVES        = 3;
  localparam int DEF_GRACE_FRAMES = 60;
  localparam int DEF_OVER_FRAMES  = 120;
  localparam int DEF_SCORE_W      = 10;

  // {menu, run, pause, over}
  function automatic logic [3:0] state_oh(
    input state_t s
  );
    logic [3:0] r;
    r = 4'b0000;
    unique case (s)
      MENU:    r = 4'b1000;
      RUN:     r = 4'b0100;
      PAUSE:   r = 4'b0010;
      OVER:    r = 4'b0001;
      default: r = 4'b1000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Button/event inputs and state/score outputs
// of the game sequencer.
interface game_state_ctrl_if
  import game_pkg::*;
#(
  parameter int SCORE_W = DEF_SCORE_W
) ();

  logic               btn_start;
  logic               btn_pause;
  logic               frame_tick;
  logic               hit;
  logic               eat;
  logic               gamemenu;
  logic               gamerun;
  logic               gamepause;
  logic               gameover;
  logic               move_tick;
  logic [SCORE_W-1:0] score;
  logic [LIVES_W-1:0] lives;
  logic               invuln;

  modport master (
    output btn_start, btn_pause,
    output frame_tick, hit, eat,
    input  gamemenu, gamerun,
    input  gamepause, gameover,
    input  move_tick, score,
    input  lives, invuln
  );

  modport slave (
    input  btn_start, btn_pause,
    input  frame_tick, hit, eat,
    output gamemenu, gamerun,
    output gamepause, gameover,
    output move_tick, score,
    output lives, invuln
  );

endinterface

// File: rtl/btn_edge.sv
// Button synchronizer with rising-edge detect.
// The edge pulse is valid in the cycle after the second sync flop.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [2:0] sr;

  // Reset high so a button held through reset gives no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= 3'b111;
    end else begin
      sr <= {sr[1:0], din};
    end
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/game_state_ctrl.sv
// EatUp game sequencer: menu/run/pause/over FSM,
// movement pacing, score and lives bookkeeping.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int MOVE_DIV     = DEF_MOVE_DIV,
  parameter int LIVES        = DEF_LIVES,
  parameter int GRACE_FRAMES = DEF_GRACE_FRAMES,
  parameter int OVER_FRAMES  = DEF_OVER_FRAMES,
  parameter int SCORE_W      = DEF_SCORE_W
) (
  input logic              clk,
  input logic              rst_n,
  game_state_ctrl_if.slave bus
);

  localparam int DIV_W =
    (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int GR_W =
    (GRACE_FRAMES > 0) ?
    $clog2(GRACE_FRAMES + 1) : 1;
  localparam int OV_W =
    (OVER_FRAMES > 0) ?
    $clog2(OVER_FRAMES + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(MOVE_DIV - 1);
  localparam logic [GR_W-1:0] GR_LOAD =
    GR_W'(GRACE_FRAMES);
  localparam logic [OV_W-1:0] OV_LOAD =
    OV_W'(OVER_FRAMES);
  localparam logic [LIVES_W-1:0] LV_LOAD =
    LIVES_W'(LIVES);

  logic               start_e;
  logic               pause_e;
  state_t             state;
  logic [3:0]         oh;
  logic               move_tick;
  logic [DIV_W-1:0]   div;
  logic [GR_W-1:0]    grace;
  logic [OV_W-1:0]    over_cnt;
  logic [SCORE_W-1:0] score;
  logic [LIVES_W-1:0] lives;
  logic               hit_ok;
  logic               fatal;

  btn_edge u_start (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.btn_start),
    .rise (start_e)
  );

  btn_edge u_pause (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.btn_pause),
    .rise (pause_e)
  );

  assign hit_ok = bus.hit && (grace == '0);
  assign fatal  = hit_ok &&
                  (lives == LIVES_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MENU;
      oh        <= state_oh(MENU);
      move_tick <= 1'b0;
      div       <= '0;
      grace     <= '0;
      over_cnt  <= '0;
      score     <= '0;
      lives     <= LV_LOAD;
    end else begin
      move_tick <= 1'b0;
      unique case (state)
        MENU: begin
          if (start_e) begin
            state <= RUN;
            oh    <= state_oh(RUN);
            score <= '0;
            lives <= LV_LOAD;
            div   <= '0;
            grace <= '0;
          end
        end
        RUN: begin
          if (bus.frame_tick) begin
            if (div == DIV_LAST) begin
              div       <= '0;
              move_tick <= 1'b1;
            end else begin
              div <= div + 1'b1;
            end
          end
          if (bus.eat && (score != '1)) begin
            score <= score + 1'b1;
          end
          // A fresh hit reloads grace over the frame decrement.
          if (hit_ok && !fatal) begin
            lives <= lives - 1'b1;
            grace <= GR_LOAD;
          end else if (bus.frame_tick &&
                       (grace != '0)) begin
            grace <= grace - 1'b1;
          end
          if (fatal) begin
            lives    <= '0;
            state    <= OVER;
            oh       <= state_oh(OVER);
            over_cnt <= OV_LOAD;
          end else if (pause_e) begin
            state <= PAUSE;
            oh    <= state_oh(PAUSE);
          end
        end
        PAUSE: begin
          if (pause_e || start_e) begin
            state <= RUN;
            oh    <= state_oh(RUN);
          end
        end
        OVER: begin
          if (start_e ||
              (bus.frame_tick &&
               (over_cnt <= OV_W'(1)))) begin
            state    <= MENU;
            oh       <= state_oh(MENU);
            over_cnt <= '0;
          end else if (bus.frame_tick) begin
            over_cnt <= over_cnt - 1'b1;
          end
        end
        default: begin
          state <= MENU;
          oh    <= state_oh(MENU);
        end
      endcase
    end
  end

  assign bus.gamemenu  = oh[3];
  assign bus.gamerun   = oh[2];
  assign bus.gamepause = oh[1];
  assign bus.gameover  = oh[0];
  assign bus.move_tick = move_tick;
  assign bus.score     = score;
  assign bus.lives     = lives;
  assign bus.invuln    = (grace != '0);

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: vector table
// plus hand sequences for buttons, grace, over and reset.
module tb_game_state_ctrl;

  localparam logic [3:0] S_MENU  = 4'b1000;
  localparam logic [3:0] S_RUN   = 4'b0100;
  localparam logic [3:0] S_PAUSE = 4'b0010;
  localparam logic [3:0] S_OVER  = 4'b0001;

  typedef struct {
    logic       ft;
    logic       hit;
    logic       eat;
    logic [3:0] st;
    logic       mv;
    int         score;
    int         lives;
  } vec_t;

  logic clk;
  logic rst_n;
  int   ncmp;
  int   nerr;
  int   mcnt;
  vec_t tbl [24];

  game_state_ctrl_if #(.SCORE_W(10)) bus ();

  game_state_ctrl #(
    .MOVE_DIV    (4),
    .LIVES       (3),
    .GRACE_FRAMES(60),
    .OVER_FRAMES (120),
    .SCORE_W     (10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] st();
    return {bus.gamemenu, bus.gamerun,
            bus.gamepause, bus.gameover};
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic cyc(
    input logic ft = 1'b0,
    input logic h  = 1'b0,
    input logic e  = 1'b0
  );
    bus.frame_tick = ft;
    bus.hit        = h;
    bus.eat        = e;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.hit        = 1'b0;
    bus.eat        = 1'b0;
    if (bus.move_tick) mcnt++;
  endtask

  task automatic press_start();
    bus.btn_start = 1'b1;
    repeat (3) cyc();
    chk("start_run", 32'(st()), 32'(S_RUN));
    chk("start_score", 32'(bus.score), 0);
    chk("start_lives", 32'(bus.lives), 3);
    bus.btn_start = 1'b0;
    repeat (4) cyc();
  endtask

  initial begin
    int s;
    ncmp = 0;
    nerr = 0;
    mcnt = 0;
    s = 0;
    for (int i = 0; i < 12; i++) begin
      tbl[2*i].ft    = 1'b1;
      tbl[2*i].hit   = 1'b0;
      tbl[2*i].eat   = (i == 5);
      if (i == 5) s++;
      tbl[2*i].st    = S_RUN;
      tbl[2*i].mv    = ((i + 1) % 4 == 0);
      tbl[2*i].score = s;
      tbl[2*i].lives = 3;
      tbl[2*i+1]     = tbl[2*i];
      tbl[2*i+1].ft  = 1'b0;
      tbl[2*i+1].eat = 1'b0;
      tbl[2*i+1].mv  = 1'b0;
    end

    rst_n          = 1'b0;
    bus.btn_start  = 1'b1;
    bus.btn_pause  = 1'b0;
    bus.frame_tick = 1'b0;
    bus.hit        = 1'b0;
    bus.eat        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(st()), 32'(S_MENU));
    chk("rst_move", 32'(bus.move_tick), 0);
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_lives", 32'(bus.lives), 3);
    chk("rst_invuln", 32'(bus.invuln), 0);
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("held_start", 32'(st()), 32'(S_MENU));
    bus.btn_start = 1'b0;
    repeat (4) cyc();
    chk("start_low", 32'(st()), 32'(S_MENU));
    bus.btn_start = 1'b1;
    cyc();
    chk("start_k", 32'(st()), 32'(S_MENU));
    cyc();
    chk("start_k1", 32'(st()), 32'(S_MENU));
    cyc();
    chk("start_k2", 32'(st()), 32'(S_RUN));
    chk("start_k2_score", 32'(bus.score), 0);
    chk("start_k2_lives", 32'(bus.lives), 3);
    repeat (3) cyc();
    chk("start_held_run", 32'(st()), 32'(S_RUN));
    bus.btn_start = 1'b0;
    repeat (4) cyc();

    mcnt = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].ft, tbl[i].hit, tbl[i].eat);
      chk($sformatf("vec%0d_st", i),
          32'(st()), 32'(tbl[i].st));
      chk($sformatf("vec%0d_mv", i),
          32'(bus.move_tick), 32'(tbl[i].mv));
      chk($sformatf("vec%0d_score", i),
          32'(bus.score), 32'(tbl[i].score));
      chk($sformatf("vec%0d_lives", i),
          32'(bus.lives), 32'(tbl[i].lives));
    end
    chk("move_count", 32'(mcnt), 3);

    cyc(1'b1);
    cyc(1'b1);
    chk("pre_pause_mv", 32'(bus.move_tick), 0);
    bus.btn_pause = 1'b1;
    repeat (2) cyc();
    chk("pause_k1", 32'(st()), 32'(S_RUN));
    cyc();
    chk("pause_k2", 32'(st()), 32'(S_PAUSE));
    bus.btn_pause = 1'b0;
    mcnt = 0;
    repeat (5) cyc(1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("paused_st", 32'(st()), 32'(S_PAUSE));
    chk("paused_moves", 32'(mcnt), 0);
    chk("paused_score", 32'(bus.score), 1);
    chk("paused_lives", 32'(bus.lives), 3);
    chk("paused_invuln", 32'(bus.invuln), 0);
    bus.btn_pause = 1'b1;
    repeat (3) cyc();
    chk("resume_run", 32'(st()), 32'(S_RUN));
    bus.btn_pause = 1'b0;
    cyc(1'b1);
    chk("resume_t1_mv", 32'(bus.move_tick), 0);
    cyc(1'b1);
    chk("resume_t2_mv", 32'(bus.move_tick), 1);
    cyc();
    chk("resume_idle_mv", 32'(bus.move_tick), 0);

    cyc(1'b0, 1'b1);
    chk("hit1_lives", 32'(bus.lives), 2);
    chk("hit1_invuln", 32'(bus.invuln), 1);
    repeat (10) cyc(1'b1);
    cyc(1'b0, 1'b1);
    chk("hit_grace_lives", 32'(bus.lives), 2);
    chk("hit_grace_invuln", 32'(bus.invuln), 1);
    repeat (49) cyc(1'b1);
    chk("grace_last", 32'(bus.invuln), 1);
    cyc(1'b1);
    chk("grace_end", 32'(bus.invuln), 0);
    cyc(1'b0, 1'b1);
    chk("hit2_lives", 32'(bus.lives), 1);
    repeat (60) cyc(1'b1);
    cyc(1'b0, 1'b1);
    chk("hit3_lives", 32'(bus.lives), 0);
    chk("hit3_over", 32'(st()), 32'(S_OVER));
    mcnt = 0;
    repeat (119) cyc(1'b1);
    chk("over_119", 32'(st()), 32'(S_OVER));
    chk("over_score", 32'(bus.score), 1);
    chk("over_lives", 32'(bus.lives), 0);
    chk("over_moves", 32'(mcnt), 0);
    cyc(1'b1);
    chk("over_120_menu", 32'(st()), 32'(S_MENU));

    press_start();
    cyc(1'b0, 1'b1);
    repeat (60) cyc(1'b1);
    cyc(1'b0, 1'b1);
    repeat (60) cyc(1'b1);
    chk("g2_lives1", 32'(bus.lives), 1);
    chk("g2_invuln", 32'(bus.invuln), 0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("g2_score2", 32'(bus.score), 2);
    bus.btn_pause = 1'b1;
    repeat (2) cyc();
    cyc(1'b0, 1'b1, 1'b1);
    chk("combo_st", 32'(st()), 32'(S_OVER));
    chk("combo_score", 32'(bus.score), 3);
    chk("combo_lives", 32'(bus.lives), 0);
    bus.btn_pause = 1'b0;
    cyc();
    chk("combo_no_pause", 32'(st()), 32'(S_OVER));
    repeat (3) cyc();
    bus.btn_start = 1'b1;
    repeat (2) cyc();
    chk("over_start_k1", 32'(st()), 32'(S_OVER));
    cyc();
    chk("over_start_menu", 32'(st()), 32'(S_MENU));
    bus.btn_start = 1'b0;
    repeat (4) cyc();

    press_start();
    repeat (1030) cyc(1'b0, 1'b0, 1'b1);
    chk("score_sat", 32'(bus.score), 1023);
    cyc(1'b0, 1'b1);
    chk("g3_hit_lives", 32'(bus.lives), 2);
    chk("g3_hit_invuln", 32'(bus.invuln), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(st()), 32'(S_MENU));
    chk("arst_score", 32'(bus.score), 0);
    chk("arst_lives", 32'(bus.lives), 3);
    chk("arst_invuln", 32'(bus.invuln), 0);
    chk("arst_move", 32'(bus.move_tick), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
